i2c_edid_reader: RTL and testbench
==================================

Name: i2c_edid_reader

Overview:
- I2C controller (initiator) that reads a block of bytes from a 7-bit-addressed device using a random-read sequence: START, dev+W, word address, repeated START, dev+R, N data bytes, STOP.
- It is the initiator counterpart of the EDID i2c_device responder.
- It is used to pull EDID from a downstream sink and to loop-test the responder on the bench.
- Runs in the 12 MHz fabric clock domain. Pins connect through the existing tristate SB_IO wrapper with data_out tied 0 (open-drain).

Parameters:
- CLK_DIV, 30, clk cycles per quarter bit-period (12 MHz / (4*30) = 100 kHz SCL); minimum 2.
- FREE_QUARTERS, 2, quarter-periods of bus-free time after STOP before done.

Ports:
- clk  input  1  fabric clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- dev_addr  input  7  target device address, latched on accepted start.
- word_addr  input  8  first register address, latched on accepted start.
- length  input  9  byte count 0..256, latched on accepted start.
- busy  output  1  high from accepted start through the done cycle.
- rd_data  output  8  received byte.
- rd_addr  output  8  register address of rd_data: word_addr + index, mod 256.
- rd_valid  output  1  one-cycle strobe per received byte.
- done  output  1  one-cycle strobe at end of request.
- error  output  1  qualifies done: NACK or bus-busy; held until next accepted start.
- scl_enable  output  1  1 = pull SCL low, 0 = release.
- scl_in  input  1  SCL pin sense.
- sda_enable  output  1  1 = pull SDA low, 0 = release.
- sda_in  input  1  SDA pin sense.

Behaviour:
- Reset (async, reset=0): state IDLE; scl_enable=0; sda_enable=0; busy=0; done=0; error=0; rd_valid=0; rd_data=0; rd_addr=0. Lines are released immediately, even mid-transfer. There is no bus-recovery clocking.
- Quarter tick: a counter 0..CLK_DIV-1 produces a one-cycle tick at wrap.
- Clock stretching: the counter holds at 0 while SCL is released and scl_in=0.
- Every bit takes 4 quarters:
  - Q0: SCL low; SDA updated at Q0 entry.
  - Q1: SCL low.
  - Q2: SCL released; stretch allowed here.
  - Q3: SCL high; sda_in sampled at Q3 entry.
- States: IDLE, START, TX_DEVW, ACK_DEVW, TX_WORD, ACK_WORD, RESTART, TX_DEVR, ACK_DEVR, RX_BYTE, TX_ACK, STOP, FREE, DONE.
- IDLE + start:
  - length=0: go to DONE next cycle; no bus activity; error=0.
  - scl_in=0 or sda_in=0: DONE with error=1; no bus activity.
  - Otherwise: latch inputs, busy=1, go to START.
- START: SDA low for 2 quarters with SCL released, then SCL low for 1 quarter.
- TX bytes are sent MSB first. dev+W = {dev_addr,0}; dev+R = {dev_addr,1}. A 1 bit releases SDA; a 0 bit pulls it low.
- ACK states: SDA released for one bit.
  - Sampled 0: next state.
  - Sampled 1 (NACK): set error=1, go to STOP.
- RESTART: SCL low with SDA released (1 quarter), release SCL (1 quarter, stretchable), pull SDA low (1 quarter), pull SCL low (1 quarter).
- RX_BYTE: SDA released; 8 bits shifted in MSB first.
  - After the 8th sample: rd_data updates and rd_valid pulses one cycle; rd_addr = word_addr + bytes_received (8-bit wrap).
  - Then go to TX_ACK.
- TX_ACK: ACK (SDA low) if more bytes remain; NACK (released) after the last byte. Then RX_BYTE or STOP.
- STOP: SCL low + SDA low (1 quarter), release SCL (1 quarter, stretchable), release SDA (1 quarter).
- FREE: FREE_QUARTERS quarters with both lines released, then DONE.
- DONE: done=1 for one cycle with error valid; busy drops the following cycle; return to IDLE.
- start while busy is ignored; no queueing.
- rd_addr wraps 0xFF→0x00 when word_addr+length > 256.
- Counters are 9-bit; length is clamped to 256 if greater.

Test Plan:
- CLK_DIV=2, bench responder ACKs dev 0x50 holding bytes 0x00..0xFF; start, word_addr=0x00, length=4 → SDA bytes 0xA0, 0x00, restart, 0xA1; rd_data 0x00..0x03 with rd_addr 0..3; ACK,ACK,ACK,NACK; STOP; done=1, error=0.
- dev_addr=0x51 with no responder → ACK_DEVW samples 1 → STOP; done with error=1; no rd_valid.
- word_addr=0xFE, length=4 → rd_addr sequence 0xFE, 0xFF, 0x00, 0x01.
- Responder holds SCL low 10 quarters during Q2 of bit 3 of the data byte → SCL high time is preserved after release; received byte is correct.
- length=0 → done one cycle after start, error=0, scl_enable/sda_enable stay 0. Separately, sda_in forced 0 in IDLE → done with error=1.
- reset asserted during RX_BYTE → scl_enable=0, sda_enable=0, busy=0 in the same cycle (async). A start after reset release runs a full normal read.

Source files
------------

// File: rtl/i2c_edid_reader.sv
// I2C initiator performing a random-read block transfer: START, dev+W, word address,
// repeated START, dev+R, N data bytes with ACK/NACK, STOP, then bus-free time.
`timescale 1ns/1ps

module i2c_edid_reader #(
    parameter int CLK_DIV       = 30,
    parameter int FREE_QUARTERS = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] dev_addr,
    input  logic [7:0] word_addr,
    input  logic [8:0] length,
    output logic       busy,
    output logic [7:0] rd_data,
    output logic [7:0] rd_addr,
    output logic       rd_valid,
    output logic       done,
    output logic       error,
    output logic       scl_enable,
    input  logic       scl_in,
    output logic       sda_enable,
    input  logic       sda_in,
    output logic [3:0] state_dbg
);

    localparam int              DIV_W     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [7:0]      FREE_LAST = 8'((FREE_QUARTERS > 0) ? FREE_QUARTERS - 1 : 0);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        START    = 4'd1,
        TX_DEVW  = 4'd2,
        ACK_DEVW = 4'd3,
        TX_WORD  = 4'd4,
        ACK_WORD = 4'd5,
        RESTART  = 4'd6,
        TX_DEVR  = 4'd7,
        ACK_DEVR = 4'd8,
        RX_BYTE  = 4'd9,
        TX_ACK   = 4'd10,
        STOP     = 4'd11,
        FREE     = 4'd12,
        DONE     = 4'd13
    } state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_cnt;
    logic             active, hold, tick, bit_end;
    logic [1:0]       quarter;
    logic [2:0]       bit_cnt;
    logic [7:0]       shreg;
    logic [7:0]       free_cnt;
    logic             ack_bit;
    logic [6:0]       dev_q;
    logic [7:0]       word_q;
    logic [8:0]       len_q;
    logic [8:0]       rx_count;
    logic             bus_busy;

    assign active    = (state_q != IDLE) && (state_q != DONE);
    // A released SCL that still reads low is a target stretching the clock.
    assign hold      = !scl_enable && !scl_in;
    assign tick      = active && !hold && (div_cnt == DIV_MAX);
    assign bit_end   = tick && (quarter == 2'd3);
    assign bus_busy  = !scl_in || !sda_in;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (!active || hold || (div_cnt == DIV_MAX)) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        scl_enable = 1'b0;
        sda_enable = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ((length == 9'd0) || bus_busy) ? DONE : START;
                end
            end
            START: begin
                sda_enable = 1'b1;
                scl_enable = (quarter == 2'd2);
                if (tick && (quarter == 2'd2)) begin
                    state_d = TX_DEVW;
                end
            end
            TX_DEVW, TX_WORD, TX_DEVR: begin
                scl_enable = !quarter[1];
                sda_enable = !shreg[7];
                if (bit_end && (bit_cnt == 3'd7)) begin
                    state_d = (state_q == TX_DEVW) ? ACK_DEVW :
                              (state_q == TX_WORD) ? ACK_WORD : ACK_DEVR;
                end
            end
            ACK_DEVW, ACK_WORD, ACK_DEVR: begin
                scl_enable = !quarter[1];
                if (bit_end) begin
                    if (ack_bit) begin
                        state_d = STOP;
                    end else begin
                        state_d = (state_q == ACK_DEVW) ? TX_WORD :
                                  (state_q == ACK_WORD) ? RESTART : RX_BYTE;
                    end
                end
            end
            RESTART: begin
                scl_enable = (quarter == 2'd0) || (quarter == 2'd3);
                sda_enable = quarter[1];
                if (bit_end) begin
                    state_d = TX_DEVR;
                end
            end
            RX_BYTE: begin
                scl_enable = !quarter[1];
                if (bit_end && (bit_cnt == 3'd7)) begin
                    state_d = TX_ACK;
                end
            end
            TX_ACK: begin
                // rx_count already includes the byte just received.
                scl_enable = !quarter[1];
                sda_enable = (rx_count != len_q);
                if (bit_end) begin
                    state_d = (rx_count == len_q) ? STOP : RX_BYTE;
                end
            end
            STOP: begin
                scl_enable = (quarter == 2'd0);
                sda_enable = (quarter != 2'd2);
                if (tick && (quarter == 2'd2)) begin
                    state_d = FREE;
                end
            end
            FREE: begin
                if (tick && (free_cnt >= FREE_LAST)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            quarter  <= 2'd0;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            free_cnt <= 8'd0;
            ack_bit  <= 1'b0;
            dev_q    <= 7'd0;
            word_q   <= 8'd0;
            len_q    <= 9'd0;
            rx_count <= 9'd0;
            rd_data  <= 8'd0;
            rd_addr  <= 8'd0;
            rd_valid <= 1'b0;
            error    <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if (state_q == IDLE) begin
                quarter  <= 2'd0;
                bit_cnt  <= 3'd0;
                free_cnt <= 8'd0;
                if (start) begin
                    dev_q    <= dev_addr;
                    word_q   <= word_addr;
                    len_q    <= (length > 9'd256) ? 9'd256 : length;
                    rx_count <= 9'd0;
                    error    <= (length != 9'd0) && bus_busy;
                end
            end else if (tick) begin
                quarter  <= (state_d != state_q) ? 2'd0 : quarter + 2'd1;
                free_cnt <= (state_q == FREE) ? free_cnt + 8'd1 : 8'd0;
                if (quarter == 2'd3) begin
                    bit_cnt <= (state_d != state_q) ? 3'd0 : bit_cnt + 3'd1;
                end
                case (state_q)
                    START: begin
                        if (quarter == 2'd2) shreg <= {dev_q, 1'b0};
                    end
                    TX_DEVW, TX_WORD, TX_DEVR: begin
                        if (quarter == 2'd3) shreg <= {shreg[6:0], 1'b1};
                    end
                    ACK_DEVW, ACK_WORD, ACK_DEVR: begin
                        if (quarter == 2'd2) ack_bit <= sda_in;
                        if ((quarter == 2'd3) && ack_bit) error <= 1'b1;
                        if ((quarter == 2'd3) && (state_q == ACK_DEVW)) shreg <= word_q;
                    end
                    RESTART: begin
                        if (quarter == 2'd3) shreg <= {dev_q, 1'b1};
                    end
                    RX_BYTE: begin
                        if (quarter == 2'd2) begin
                            shreg <= {shreg[6:0], sda_in};
                            if (bit_cnt == 3'd7) begin
                                rd_data  <= {shreg[6:0], sda_in};
                                rd_addr  <= word_q + rx_count[7:0];
                                rd_valid <= 1'b1;
                                rx_count <= rx_count + 9'd1;
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_edid_reader.sv
// Bench for i2c_edid_reader: behavioural I2C target at 0x50 serving addr^key bytes,
// randomized reads checked against a transaction-level model and an expected queue.
`timescale 1ns/1ps

module tb_i2c_edid_reader;

    localparam int         CLK_DIV   = 2;
    localparam logic [6:0] RESP_ADDR = 7'h50;

    // clock / reset
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0;
    logic [6:0] dev_addr = 7'd0;
    logic [7:0] word_addr = 8'd0;
    logic [8:0] length = 9'd0;
    logic       busy, rd_valid, done, error, scl_enable, sda_enable;
    logic [7:0] rd_data, rd_addr;
    logic [3:0] state_dbg;
    logic       scl_line, sda_line;

    logic r_scl_low = 1'b0;
    logic r_sda_low = 1'b0;
    logic force_sda_low = 1'b0;
    logic resp_rst = 1'b0;
    logic stretch_req = 1'b0;

    assign scl_line = ~scl_enable & ~r_scl_low;
    assign sda_line = ~sda_enable & ~r_sda_low & ~force_sda_low;

    i2c_edid_reader #(.CLK_DIV(CLK_DIV), .FREE_QUARTERS(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dev_addr   (dev_addr),
        .word_addr  (word_addr),
        .length     (length),
        .busy       (busy),
        .rd_data    (rd_data),
        .rd_addr    (rd_addr),
        .rd_valid   (rd_valid),
        .done       (done),
        .error      (error),
        .scl_enable (scl_enable),
        .scl_in     (scl_line),
        .sda_enable (sda_enable),
        .sda_in     (sda_line),
        .state_dbg  (state_dbg)
    );

    // scoreboard state
    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] exp_q[$];
    logic [7:0]  seen_q[$];
    logic        mack_q[$];
    logic [7:0]  mem[256];
    int rd_cnt = 0;
    int act_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // behavioural I2C target
    typedef enum logic [2:0] {R_IDLE, R_ADDR, R_AACK, R_WORD, R_WACK, R_TX, R_MACK} r_phase_t;
    r_phase_t   r_phase = R_IDLE;
    logic       scl_d = 1'b1, sda_d = 1'b1;
    logic [7:0] r_shift = 8'd0, r_tx = 8'd0, r_ptr = 8'd0;
    logic [3:0] r_bits = 4'd0;
    logic       r_rw = 1'b0, r_mack = 1'b0;
    int         r_tx_idx = 0, stretch_cnt = 0, stretch_hits = 0;
    bit         meas_arm = 1'b0;
    int         hi_cnt = 0, hi_len = -1;

    wire start_det = scl_line && scl_d && sda_d && !sda_line;
    wire stop_det  = scl_line && scl_d && !sda_d && sda_line;
    wire scl_rise  = scl_line && !scl_d;
    wire scl_fall  = !scl_line && scl_d;

    always @(posedge clk) begin
        scl_d <= scl_line;
        sda_d <= sda_line;
        if (meas_arm) begin
            if (scl_line) hi_cnt <= hi_cnt + 1;
            else if (hi_cnt > 0) begin
                hi_len   <= hi_cnt;
                meas_arm <= 1'b0;
            end
        end
        if (resp_rst) begin
            r_phase     <= R_IDLE;
            r_sda_low   <= 1'b0;
            r_scl_low   <= 1'b0;
            stretch_cnt <= 0;
        end else begin
            if (stretch_cnt > 0) begin
                stretch_cnt <= stretch_cnt - 1;
                if (stretch_cnt == 1) begin
                    r_scl_low <= 1'b0;
                    meas_arm  <= 1'b1;
                    hi_cnt    <= 0;
                end
            end
            if (start_det) begin
                r_phase   <= R_ADDR;
                r_bits    <= 4'd0;
                r_sda_low <= 1'b0;
            end else if (stop_det) begin
                r_phase   <= R_IDLE;
                r_sda_low <= 1'b0;
            end else if (scl_rise) begin
                if (r_phase == R_ADDR || r_phase == R_WORD) begin
                    r_shift <= {r_shift[6:0], sda_line};
                    r_bits  <= r_bits + 4'd1;
                end else if (r_phase == R_MACK) begin
                    r_mack <= sda_line;
                end
            end else if (scl_fall) begin
                case (r_phase)
                    R_ADDR: if (r_bits == 4'd8) begin
                        seen_q.push_back(r_shift);
                        if (r_shift[7:1] == RESP_ADDR) begin
                            r_sda_low <= 1'b1;
                            r_rw      <= r_shift[0];
                            r_phase   <= R_AACK;
                        end else begin
                            r_phase <= R_IDLE;
                        end
                    end
                    R_AACK: begin
                        r_bits <= 4'd0;
                        if (!r_rw) begin
                            r_sda_low <= 1'b0;
                            r_phase   <= R_WORD;
                        end else begin
                            r_tx      <= mem[r_ptr];
                            r_sda_low <= !mem[r_ptr][7];
                            r_tx_idx  <= 0;
                            r_phase   <= R_TX;
                        end
                    end
                    R_WORD: if (r_bits == 4'd8) begin
                        seen_q.push_back(r_shift);
                        r_ptr     <= r_shift;
                        r_sda_low <= 1'b1;
                        r_phase   <= R_WACK;
                    end
                    R_WACK: begin
                        r_sda_low <= 1'b0;
                        r_phase   <= R_IDLE;
                    end
                    R_TX: begin
                        if (r_bits == 4'd7) begin
                            r_sda_low <= 1'b0;
                            r_phase   <= R_MACK;
                        end else begin
                            r_sda_low <= !r_tx[6 - r_bits];
                            r_bits    <= r_bits + 4'd1;
                            if (stretch_req && r_tx_idx == 0 && r_bits == 4'd2) begin
                                r_scl_low    <= 1'b1;
                                stretch_cnt  <= 10 * CLK_DIV;
                                stretch_hits <= stretch_hits + 1;
                            end
                        end
                    end
                    R_MACK: begin
                        mack_q.push_back(r_mack);
                        r_ptr <= r_ptr + 8'd1;
                        if (!r_mack) begin
                            r_tx      <= mem[8'(r_ptr + 8'd1)];
                            r_sda_low <= !mem[8'(r_ptr + 8'd1)][7];
                            r_bits    <= 4'd0;
                            r_tx_idx  <= r_tx_idx + 1;
                            r_phase   <= R_TX;
                        end else begin
                            r_phase <= R_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // output monitors
    always @(negedge clk) begin
        if (scl_enable || sda_enable) act_cnt <= act_cnt + 1;
        if (rd_valid) begin
            rd_cnt <= rd_cnt + 1;
            if (exp_q.size() > 0) check_eq("rd_addr_data", {rd_addr, rd_data}, exp_q.pop_front());
        end
    end

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // driver + transaction-level model
    task automatic run_read(input logic [6:0] dev, input logic [7:0] w, input logic [8:0] len,
                            input logic [7:0] key);
        int n, rd0, act0, ones;
        bit exp_err, quiet, got_done;
        logic [7:0] exp_seen[$];
        logic [7:0] a;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ key;
        n = (len > 9'd256) ? 256 : int'(len);
        exp_err = 1'b0;
        quiet = 1'b0;
        if (n == 0) begin
            quiet = 1'b1;
        end else if (force_sda_low) begin
            exp_err = 1'b1;
            quiet = 1'b1;
            n = 0;
        end else begin
            exp_seen.push_back({dev, 1'b0});
            if (dev == RESP_ADDR) begin
                exp_seen.push_back(w);
                exp_seen.push_back({dev, 1'b1});
                for (int i = 0; i < n; i++) begin
                    a = 8'((int'(w) + i) % 256);
                    exp_q.push_back({a, a ^ key});
                end
            end else begin
                exp_err = 1'b1;
                n = 0;
            end
        end
        seen_q.delete();
        mack_q.delete();
        rd0 = rd_cnt;
        act0 = act_cnt;
        @(negedge clk);
        dev_addr = dev; word_addr = w; length = len; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        if (quiet) check_eq("quick_done", done, 1);
        wait_done(2000 + n * 100, got_done);
        check_eq("done_seen", got_done, 1);
        check_eq("error", error, exp_err);
        check_eq("rd_count", rd_cnt - rd0, n);
        check_eq("exp_q_left", exp_q.size(), 0);
        check_eq("seen_size", seen_q.size(), exp_seen.size());
        for (int i = 0; i < seen_q.size() && i < exp_seen.size(); i++)
            check_eq("seen_byte", seen_q[i], exp_seen[i]);
        ones = 0;
        foreach (mack_q[i]) ones += int'(mack_q[i]);
        check_eq("mack_count", mack_q.size(), n);
        check_eq("mack_ones", ones, (n > 0) ? 1 : 0);
        if (n > 0 && mack_q.size() > 0) check_eq("mack_last", mack_q[mack_q.size() - 1], 1);
        if (quiet) check_eq("bus_quiet", act_cnt - act0, 0);
        @(negedge clk);
        check_eq("busy_drop", busy, 0);
        check_eq("done_pulse", done, 0);
        check_eq("error_held", error, exp_err);
        check_eq("scl_released", scl_enable, 0);
        check_eq("sda_released", sda_enable, 0);
        exp_q.delete();
    endtask

    initial begin
        int rd0;
        logic [6:0] dev;
        #15;
        check_eq("rst_scl", scl_enable, 0);
        check_eq("rst_sda", sda_enable, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_error", error, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_rd_addr", rd_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        run_read(7'h50, 8'h00, 9'd4, 8'h00);
        run_read(7'h51, 8'h00, 9'd4, 8'h00);
        run_read(7'h50, 8'hFE, 9'd4, 8'($urandom));

        stretch_req = 1'b1;
        run_read(7'h50, 8'h10, 9'd2, 8'h5A);
        stretch_req = 1'b0;
        check_eq("stretch_hits", stretch_hits, 1);
        check_eq("stretch_scl_high", hi_len, 2 * CLK_DIV);

        run_read(7'h50, 8'h20, 9'd0, 8'h00);
        force_sda_low = 1'b1;
        run_read(7'h50, 8'h20, 9'd3, 8'h00);
        force_sda_low = 1'b0;

        // asynchronous reset in the middle of a data byte
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        rd0 = rd_cnt;
        @(negedge clk);
        dev_addr = 7'h50; word_addr = 8'h40; length = 9'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 5000 && (rd_cnt - rd0) < 2; i++) @(negedge clk);
        check_eq("mid_rx_reached", (rd_cnt - rd0) >= 2, 1);
        repeat (10) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_scl", scl_enable, 0);
        check_eq("async_rst_sda", sda_enable, 0);
        check_eq("async_rst_busy", busy, 0);
        resp_rst = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        resp_rst = 1'b0;
        repeat (2) @(negedge clk);
        run_read(7'h50, 8'h33, 9'd5, 8'hC3);

        // randomized reads
        for (int t = 0; t < 10; t++) begin
            dev = ($urandom_range(0, 3) == 0) ? (RESP_ADDR ^ 7'($urandom_range(1, 127))) : RESP_ADDR;
            run_read(dev, 8'($urandom), 9'($urandom_range(1, 20)), 8'($urandom));
        end

        // length above 256 is clamped
        run_read(7'h50, 8'($urandom), 9'd300, 8'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
